// File: rtl/input_vc_buffer.sv
// Purpose : per-(input port, VC) flit buffer with head/VA/active packet FSM feeding the switch allocator.
// Latency : a head written at cycle t is examined at t+1, requests a VC at t+2, requests the switch at t+3 at the earliest.
// Backpr. : on_off_o drops when free slots <= OFF_MARGIN; a write into a full FIFO with no pop is dropped and sets error_o.
//
// Ports:
//   clk, rst (async active-low)
//   data_i / valid_flit_i        incoming flit from the upstream router
//   route_port_i                 output port computed from flit_o, latched when a head is accepted
//   vc_valid_i / vc_new_i        VC allocator grant and granted downstream VC
//   read_i                       switch-allocation grant, pops the front flit while ACTIVE
//   flit_o, is_empty_o           FIFO front and empty flag
//   va_request_o, switch_request_o, out_port_o, downstream_vc_o
//   on_off_o                     flow-control bit to upstream, error_o sticky protocol/overflow error

// Generic storage FIFO: push/pop bookkeeping only, the caller decides legality.
// Front flit is read combinationally from storage; a push is visible the next cycle.
// Caller must never push when full without a pop, nor pop when empty.
module vc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             front_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign front_dat = mem[rd_ptr];
endmodule

module input_vc_buffer #(
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_W      = 32,
    parameter int OFF_MARGIN  = 2,
    parameter int PORT_SIZE   = 3,
    parameter int VC_SIZE     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_W-1:0]    data_i,
    input  logic                 valid_flit_i,
    input  logic [PORT_SIZE-1:0] route_port_i,
    input  logic                 vc_valid_i,
    input  logic [VC_SIZE-1:0]   vc_new_i,
    input  logic                 read_i,
    output logic [FLIT_W-1:0]    flit_o,
    output logic                 is_empty_o,
    output logic                 va_request_o,
    output logic                 switch_request_o,
    output logic [PORT_SIZE-1:0] out_port_o,
    output logic [VC_SIZE-1:0]   downstream_vc_o,
    output logic                 on_off_o,
    output logic                 error_o
);
    localparam int CW = $clog2(BUFFER_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VA     = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] free_slots;
    logic          empty;
    logic          full;
    logic [1:0]    front_type;
    logic          front_is_head;
    logic          front_is_last;
    logic          read_pop;
    logic          discard_pop;
    logic          pop;
    logic          push;
    logic          overflow;
    logic          latch_port;
    logic          latch_vc;

    vc_fifo #(
        .DEPTH (BUFFER_SIZE),
        .W     (FLIT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push),
        .push_dat  (data_i),
        .pop_vld   (pop),
        .front_dat (flit_o),
        .count     (count)
    );

    assign empty      = (count == '0);
    assign full       = (count == CW'(BUFFER_SIZE));
    assign is_empty_o = empty;

    // Type field: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
    // Heads have equal type bits; packet-ending flits have the top bit set.
    assign front_type    = flit_o[FLIT_W-1 -: 2];
    assign front_is_head = (front_type[1] == front_type[0]);
    assign front_is_last = front_type[1];

    // Switch grants only count while ACTIVE with data present.
    assign read_pop    = read_i && (state == ACTIVE) && !empty;
    // A non-head flit at the front while IDLE is an orphan from a broken packet.
    assign discard_pop = (state == IDLE) && !empty && !front_is_head;
    assign pop         = read_pop || discard_pop;

    // A pop in the same cycle frees the slot the incoming flit needs.
    assign push     = valid_flit_i && (!full || pop);
    assign overflow = valid_flit_i && full && !pop;

    // Free-slot threshold leaves room for flits already in flight on the link.
    assign free_slots = CW'(BUFFER_SIZE) - count;
    assign on_off_o   = (free_slots > CW'(OFF_MARGIN));

    always_comb begin
        state_nxt        = state;
        latch_port       = 1'b0;
        latch_vc         = 1'b0;
        va_request_o     = 1'b0;
        switch_request_o = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && front_is_head) begin
                    latch_port = 1'b1;
                    state_nxt  = VA;
                end
            end
            VA: begin
                va_request_o = 1'b1;
                if (vc_valid_i) begin
                    latch_vc  = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                switch_request_o = !empty;
                if (read_pop && front_is_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            out_port_o      <= '0;
            downstream_vc_o <= '0;
            error_o         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_port) begin
                out_port_o <= route_port_i;
            end
            if (latch_vc) begin
                downstream_vc_o <= vc_new_i;
            end
            if (overflow || discard_pop) begin
                error_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer: a queue holds every accepted flit and is
// compared against flit_o whenever a switch grant pops the front.
module tb_input_vc_buffer;
    localparam int FW = 32;
    localparam int PW = 3;
    localparam int VW = 1;
    localparam int BS = 8;
    localparam int OM = 2;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          valid_flit_i = 1'b0;
    logic [PW-1:0] route_port_i = '0;
    logic          vc_valid_i = 1'b0;
    logic [VW-1:0] vc_new_i = '0;
    logic          read_i = 1'b0;
    logic [FW-1:0] flit_o;
    logic          is_empty_o;
    logic          va_request_o;
    logic          switch_request_o;
    logic [PW-1:0] out_port_o;
    logic [VW-1:0] downstream_vc_o;
    logic          on_off_o;
    logic          error_o;

    logic [FW-1:0] expq [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc;

    input_vc_buffer #(
        .BUFFER_SIZE (BS),
        .FLIT_W      (FW),
        .OFF_MARGIN  (OM),
        .PORT_SIZE   (PW),
        .VC_SIZE     (VW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .valid_flit_i     (valid_flit_i),
        .route_port_i     (route_port_i),
        .vc_valid_i       (vc_valid_i),
        .vc_new_i         (vc_new_i),
        .read_i           (read_i),
        .flit_o           (flit_o),
        .is_empty_o       (is_empty_o),
        .va_request_o     (va_request_o),
        .switch_request_o (switch_request_o),
        .out_port_o       (out_port_o),
        .downstream_vc_o  (downstream_vc_o),
        .on_off_o         (on_off_o),
        .error_o          (error_o)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int p);
        return {t, 30'(p)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [FW-1:0] f, input bit accept);
        data_i       = f;
        valid_flit_i = 1'b1;
        if (accept) expq.push_back(f);
        tick();
        valid_flit_i = 1'b0;
    endtask

    task automatic grant_vc(input logic [VW-1:0] vc);
        vc_valid_i = 1'b1;
        vc_new_i   = vc;
        tick();
        vc_valid_i = 1'b0;
    endtask

    // Hold read_i high until n flits have been popped or the budget runs out.
    task automatic drain(input int n, output int cycles);
        int got;
        got    = 0;
        cycles = 0;
        read_i = 1'b1;
        while (got < n && cycles < n + 16) begin
            if (switch_request_o) begin
                if (expq.size() > 0) chk("pop_dat", flit_o, expq.pop_front());
                got++;
            end
            tick();
            cycles++;
        end
        read_i = 1'b0;
        chk("pop_cnt", got, n);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        valid_flit_i = 1'b0;
        read_i       = 1'b0;
        vc_valid_i   = 1'b0;
        data_i       = '0;
        expq.delete();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_empty", is_empty_o, 1);
        chk("rst_onoff", on_off_o, 1);
        chk("rst_va", va_request_o, 0);
        chk("rst_sw", switch_request_o, 0);
        chk("rst_port", out_port_o, 0);
        chk("rst_dvc", downstream_vc_o, 0);
        chk("rst_err", error_o, 0);

        // Single HEADTAIL packet at minimum latency
        route_port_i = 3'd3;
        wr(mk(T_HT, 'h11), 1);
        chk("ht_notempty", is_empty_o, 0);
        chk("ht_va_early", va_request_o, 0);
        tick();
        chk("ht_va", va_request_o, 1);
        chk("ht_port", out_port_o, 3);
        grant_vc(1'b1);
        chk("ht_sw", switch_request_o, 1);
        chk("ht_va_off", va_request_o, 0);
        chk("ht_dvc", downstream_vc_o, 1);
        drain(1, cyc);
        chk("ht_empty", is_empty_o, 1);
        chk("ht_sw_off", switch_request_o, 0);

        // Four-flit packet, consecutive pops
        route_port_i = 3'd2;
        wr(mk(T_HEAD, 'h21), 1);
        wr(mk(T_BODY, 'h22), 1);
        chk("pk_va", va_request_o, 1);
        vc_valid_i = 1'b1;
        vc_new_i   = 1'b0;
        wr(mk(T_BODY, 'h23), 1);
        vc_valid_i = 1'b0;
        wr(mk(T_TAIL, 'h24), 1);
        drain(4, cyc);
        chk("pk_consec", cyc, 4);
        chk("pk_err", error_o, 0);
        chk("pk_empty", is_empty_o, 1);
        chk("pk_port", out_port_o, 2);
        chk("pk_dvc", downstream_vc_o, 0);
        // Back in IDLE: a new head moves straight on to VA.
        route_port_i = 3'd6;
        wr(mk(T_HT, 'h25), 1);
        tick();
        chk("pk_idle_va", va_request_o, 1);
        chk("pk_idle_port", out_port_o, 6);

        // Fill without reads, on_off threshold, overflow drop
        do_reset();
        route_port_i = 3'd1;
        for (int k = 1; k <= BS; k++) begin
            wr(mk(k == 1 ? T_HEAD : T_BODY, 'h30 + k), 1);
            chk("fill_onoff", on_off_o, ((BS - k) > OM) ? 1 : 0);
        end
        chk("fill_err0", error_o, 0);
        wr(mk(T_TAIL, 'h3F), 0);
        chk("ovf_err", error_o, 1);
        chk("ovf_onoff", on_off_o, 0);
        grant_vc(1'b0);
        drain(BS, cyc);
        chk("ovf_empty", is_empty_o, 1);

        // Full FIFO in ACTIVE: write and pop in the same cycle
        do_reset();
        route_port_i = 3'd4;
        for (int k = 1; k <= BS; k++) begin
            wr(mk(k == 1 ? T_HEAD : T_BODY, 'h40 + k), 1);
        end
        grant_vc(1'b1);
        chk("fa_sw", switch_request_o, 1);
        chk("fa_front", flit_o, expq.pop_front());
        read_i = 1'b1;
        wr(mk(T_TAIL, 'h4F), 1);
        read_i = 1'b0;
        chk("fa_err", error_o, 0);
        chk("fa_onoff", on_off_o, 0);
        chk("fa_notempty", is_empty_o, 0);
        drain(BS, cyc);
        chk("fa_empty", is_empty_o, 1);
        chk("fa_err_end", error_o, 0);

        // Orphan BODY in IDLE is discarded, next packet proceeds
        do_reset();
        wr(mk(T_BODY, 'h51), 0);
        chk("orph_notempty", is_empty_o, 0);
        chk("orph_err0", error_o, 0);
        tick();
        chk("orph_empty", is_empty_o, 1);
        chk("orph_err", error_o, 1);
        chk("orph_va", va_request_o, 0);
        route_port_i = 3'd5;
        wr(mk(T_HEAD, 'h52), 1);
        tick();
        chk("orph_hd_va", va_request_o, 1);
        chk("orph_hd_port", out_port_o, 5);
        grant_vc(1'b1);
        chk("orph_hd_sw", switch_request_o, 1);
        wr(mk(T_TAIL, 'h53), 1);
        drain(2, cyc);
        chk("orph_done", is_empty_o, 1);

        // Asynchronous reset while ACTIVE with three flits buffered
        route_port_i = 3'd7;
        wr(mk(T_HEAD, 'h61), 1);
        wr(mk(T_BODY, 'h62), 1);
        wr(mk(T_BODY, 'h63), 1);
        grant_vc(1'b1);
        chk("ar_sw_pre", switch_request_o, 1);
        rst = 1'b0;
        #1;
        chk("ar_empty", is_empty_o, 1);
        chk("ar_sw", switch_request_o, 0);
        chk("ar_onoff", on_off_o, 1);
        chk("ar_port", out_port_o, 0);
        chk("ar_err", error_o, 0);
        expq.delete();
        tick();
        rst = 1'b1;
        tick();
        chk("ar_after", is_empty_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
